// File: rtl/gemm_tile_sequencer_pkg.sv
// Config: shared configuration for the GEMM tile path.
//   SMALL_SYS_ROWS/COLS : systolic array geometry of the small configuration
//   TILE_K_MAX/N_MAX    : largest tile depth/width the array can consume
//   seq_state_e         : tile sequencer FSM states
package Config;

  localparam int unsigned SMALL_SYS_ROWS = 4;
  localparam int unsigned SMALL_SYS_COLS = 4;

  localparam int unsigned TILE_K_MAX = 16;
  localparam int unsigned TILE_N_MAX = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// Command/tile bus of the GEMM tile sequencer.
//   cmd_valid/cmd_ready, cmd_k, cmd_n : one GEMM command (depth K, width N)
//   tile_valid/tile_ready             : tile descriptor handshake
//   ksize, nsize, k_off, n_off        : tile geometry and position
//   first_k, last_k, last_tile        : accumulation / command markers
//   done                              : one-cycle end-of-command pulse
// modport master is the sequencer side, modport slave the surrounding logic.
interface gemm_tile_sequencer_if #(
  parameter int unsigned DIM_W = 16
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIM_W-1:0] cmd_k;
  logic [DIM_W-1:0] cmd_n;
  logic             tile_valid;
  logic             tile_ready;
  logic [4:0]       ksize;
  logic [4:0]       nsize;
  logic [DIM_W-1:0] k_off;
  logic [DIM_W-1:0] n_off;
  logic             first_k;
  logic             last_k;
  logic             last_tile;
  logic             done;

  modport master (
    input  cmd_valid, cmd_k, cmd_n, tile_ready,
    output cmd_ready, tile_valid, ksize, nsize, k_off, n_off,
           first_k, last_k, last_tile, done
  );

  modport slave (
    output cmd_valid, cmd_k, cmd_n, tile_ready,
    input  cmd_ready, tile_valid, ksize, nsize, k_off, n_off,
           first_k, last_k, last_tile, done
  );

endinterface

// File: rtl/gemm_tile_sequencer_dim_calc.sv
// tile_dim_calc: clips the remaining extent of one dimension to a tile.
//   remain : elements still to cover (total minus current offset)
//   size   : min(TILE_MAX, remain)
//   last   : this tile covers the rest of the dimension
module tile_dim_calc #(
  parameter int unsigned DIM_W    = 16,
  parameter int unsigned TILE_MAX = 16
) (
  input  logic [DIM_W-1:0] remain,
  output logic [4:0]       size,
  output logic             last
);

  always_comb begin
    last = (remain <= DIM_W'(TILE_MAX));
    // remain is at most TILE_MAX (< 32) whenever it is selected
    size = last ? remain[4:0] : 5'(TILE_MAX);
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: splits one GEMM command (depth K, width N) into
// systolic-array tiles, N-outer / K-inner, one tile per cycle when the
// consumer is ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : command in, tile descriptor out, done pulse (master modport)
// All outputs are registered.
module gemm_tile_sequencer
  import Config::*;
#(
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned TILE_K = TILE_K_MAX,
  parameter int unsigned TILE_N = TILE_N_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  gemm_tile_sequencer_if.master bus
);

  seq_state_e       state;
  logic [DIM_W-1:0] k_tot;
  logic [DIM_W-1:0] n_tot;
  logic [DIM_W-1:0] k_off;
  logic [DIM_W-1:0] n_off;
  logic [4:0]       ksize;
  logic [4:0]       nsize;
  logic             first_k;
  logic             last_k;
  logic             last_tile;
  logic             tile_valid;
  logic             cmd_ready;
  logic             done;

  logic [DIM_W-1:0] nxt_k_tot;
  logic [DIM_W-1:0] nxt_n_tot;
  logic [DIM_W-1:0] nxt_k_off;
  logic [DIM_W-1:0] nxt_n_off;
  logic [DIM_W-1:0] rem_k;
  logic [DIM_W-1:0] rem_n;
  logic [4:0]       calc_ksize;
  logic [4:0]       calc_nsize;
  logic             calc_klast;
  logic             calc_nlast;

  // Geometry of the tile that would be presented next. The descriptor is
  // computed one step ahead so it can be loaded into output registers.
  // Offsets only advance when the remainder exceeds the tile size, so the
  // additions cannot wrap when their result is used.
  always_comb begin
    nxt_k_tot = k_tot;
    nxt_n_tot = n_tot;
    nxt_k_off = k_off;
    nxt_n_off = n_off;
    case (state)
      IDLE: begin
        nxt_k_tot = bus.cmd_k;
        nxt_n_tot = bus.cmd_n;
        nxt_k_off = '0;
        nxt_n_off = '0;
      end
      ISSUE: begin
        if (!last_k) begin
          nxt_k_off = k_off + DIM_W'(TILE_K);
        end else begin
          nxt_k_off = '0;
          nxt_n_off = n_off + DIM_W'(TILE_N);
        end
      end
      default: ;
    endcase
    rem_k = nxt_k_tot - nxt_k_off;
    rem_n = nxt_n_tot - nxt_n_off;
  end

  tile_dim_calc #(
    .DIM_W    (DIM_W),
    .TILE_MAX (TILE_K)
  ) u_calc_k (
    .remain (rem_k),
    .size   (calc_ksize),
    .last   (calc_klast)
  );

  tile_dim_calc #(
    .DIM_W    (DIM_W),
    .TILE_MAX (TILE_N)
  ) u_calc_n (
    .remain (rem_n),
    .size   (calc_nsize),
    .last   (calc_nlast)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k_tot      <= '0;
      n_tot      <= '0;
      k_off      <= '0;
      n_off      <= '0;
      ksize      <= '0;
      nsize      <= '0;
      first_k    <= 1'b0;
      last_k     <= 1'b0;
      last_tile  <= 1'b0;
      tile_valid <= 1'b0;
      cmd_ready  <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            k_tot     <= nxt_k_tot;
            n_tot     <= nxt_n_tot;
            k_off     <= '0;
            n_off     <= '0;
            cmd_ready <= 1'b0;
            if ((bus.cmd_k == '0) || (bus.cmd_n == '0)) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state      <= ISSUE;
              tile_valid <= 1'b1;
              ksize      <= calc_ksize;
              nsize      <= calc_nsize;
              first_k    <= 1'b1;
              last_k     <= calc_klast;
              last_tile  <= calc_klast & calc_nlast;
            end
          end
        end
        ISSUE: begin
          if (bus.tile_ready) begin
            if (!last_tile) begin
              k_off     <= nxt_k_off;
              n_off     <= nxt_n_off;
              ksize     <= calc_ksize;
              nsize     <= calc_nsize;
              first_k   <= (nxt_k_off == '0);
              last_k    <= calc_klast;
              last_tile <= calc_klast & calc_nlast;
            end else begin
              state      <= FINISH;
              tile_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        FINISH: begin
          state     <= IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          tile_valid <= 1'b0;
          done       <= 1'b0;
          cmd_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.tile_valid = tile_valid;
  assign bus.ksize      = ksize;
  assign bus.nsize      = nsize;
  assign bus.k_off      = k_off;
  assign bus.n_off      = n_off;
  assign bus.first_k    = first_k;
  assign bus.last_k     = last_k;
  assign bus.last_tile  = last_tile;
  assign bus.done       = done;

endmodule
